// File: rtl/uart_tx_frame_if.sv
// Frame request channel into uart_tx_frame: payload, per-frame format and the valid/ready handshake.
// The parity controls exist only when UART_TX_PARITY_EN is defined.
interface uart_tx_frame_if #(
    parameter int DATA_W = 8
);
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic [3:0]        nbits;
    logic              stop2;
`ifdef UART_TX_PARITY_EN
    logic              parity_en;
    logic              parity_odd;

    modport master (output tx_valid, tx_data, nbits, stop2, parity_en, parity_odd,
                    input  tx_ready);
    modport slave  (input  tx_valid, tx_data, nbits, stop2, parity_en, parity_odd,
                    output tx_ready);
`else
    modport master (output tx_valid, tx_data, nbits, stop2,
                    input  tx_ready);
    modport slave  (input  tx_valid, tx_data, nbits, stop2,
                    output tx_ready);
`endif
endinterface

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: runtime data length, one/two stop bits, baud tick as clock enable.
// Optional parity bit compiled in with UART_TX_PARITY_EN.
module uart_tx_frame #(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic           tick,
    uart_tx_frame_if.slave host,
    output logic           tx,
    output logic           busy,
    output logic           tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [3:0]        idx_q, idx_d;
    logic [3:0]        last_q, last_d;
    logic              stop2_q, stop2_d;
    logic              stop_sec_q, stop_sec_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic [3:0]        nbits_c;
    logic              accept;
    logic              bit_end;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;
    logic              par_en_q, par_en_d;
    logic              par_calc;
`endif

    assign accept  = host.tx_valid && (state_q == S_IDLE);
    assign bit_end = (state_q != S_IDLE) && tick && (cnt_q == CNT_W'(OVERSAMPLE - 1));

    always_comb begin
        nbits_c = host.nbits;
        if (host.nbits < 4'd5)
            nbits_c = 4'd5;
        else if (host.nbits > 4'(DATA_W))
            nbits_c = 4'(DATA_W);
    end

`ifdef UART_TX_PARITY_EN
    // Only the bits that will actually be sent contribute to parity.
    always_comb begin
        par_calc = host.parity_odd;
        for (int i = 0; i < DATA_W; i++)
            if (4'(i) < nbits_c)
                par_calc = par_calc ^ host.tx_data[i];
    end
`endif

    always_comb begin
        // NOTE: every output of this block is assigned a default first so no latch is inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        last_d     = last_q;
        stop2_d    = stop2_q;
        stop_sec_d = stop_sec_q;
        done_d     = 1'b0;
        tx_d       = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
        par_en_d   = par_en_q;
`endif

        if (state_q != S_IDLE && tick)
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d    = S_START;
                    cnt_d      = '0;
                    shift_d    = host.tx_data;
                    idx_d      = 4'd0;
                    last_d     = nbits_c - 4'd1;
                    stop2_d    = host.stop2;
                    stop_sec_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_d      = par_calc;
                    par_en_d   = host.parity_en;
`endif
                end
            end
            S_START: begin
                if (bit_end)
                    state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == last_q) begin
`ifdef UART_TX_PARITY_EN
                        state_d = par_en_q ? S_PARITY : S_STOP;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end)
                    state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_sec_q) begin
                        stop_sec_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // tx is registered from the next state so the line changes on the same edge as the state.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            idx_q      <= 4'd0;
            last_q     <= 4'd0;
            stop2_q    <= 1'b0;
            stop_sec_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            stop2_q    <= stop2_d;
            stop_sec_q <= stop_sec_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
            par_en_q   <= par_en_d;
`endif
        end
    end

    assign tx            = tx_q;
    assign tx_done       = done_q;
    assign busy          = (state_q != S_IDLE);
    assign host.tx_ready = (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: frame-level model of the serial waveform compared every
// cycle, plus literal bit samples and frame latencies.
`timescale 1ns/1ps
module tb_uart_tx_frame;
    localparam int DATA_W = 8;
    localparam int OS     = 16;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b1;
    logic tick;
    logic tx;
    logic busy;
    logic tx_done;

    uart_tx_frame_if #(.DATA_W(DATA_W)) bus ();

    uart_tx_frame #(.DATA_W(DATA_W), .OVERSAMPLE(OS)) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .tick    (tick),
        .host    (bus),
        .tx      (tx),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame model: the expected line is the bit list of the frame, each entry lasting OS ticks.
    bit  m_active = 1'b0;
    bit  exp_done = 1'b0;
    bit  m_bits[$];
    bit  m_par;
    int  m_n;
    int  elapsed  = 0;
    int  cyc      = 0;
    int  tick_cnt = 0;
    int  acc_cnt  = 0;
    int  acc_cyc  = 0;
    int  acc_tick = 0;

    initial begin
        forever begin
            @(posedge Clk or negedge Rst_n);
            if (!Rst_n) begin
                m_active = 1'b0;
                exp_done = 1'b0;
            end else begin
                cyc++;
                exp_done = 1'b0;
                if (tick)
                    tick_cnt++;
                if (m_active) begin
                    if (tick)
                        elapsed++;
                    if (elapsed == OS * m_bits.size()) begin
                        m_active = 1'b0;
                        exp_done = 1'b1;
                    end
                end else if (bus.tx_valid) begin
                    m_n = int'(bus.nbits);
                    if (m_n < 5)
                        m_n = 5;
                    if (m_n > DATA_W)
                        m_n = DATA_W;
                    m_bits = {};
                    m_bits.push_back(1'b0);
                    m_par = 1'b0;
                    for (int i = 0; i < m_n; i++) begin
                        m_bits.push_back(bus.tx_data[i]);
                        m_par = m_par ^ bus.tx_data[i];
                    end
`ifdef UART_TX_PARITY_EN
                    if (bus.parity_en)
                        m_bits.push_back(m_par ^ bus.parity_odd);
`endif
                    m_bits.push_back(1'b1);
                    if (bus.stop2)
                        m_bits.push_back(1'b1);
                    m_active = 1'b1;
                    elapsed  = 0;
                    acc_cnt++;
                    acc_cyc  = cyc;
                    acc_tick = tick_cnt;
                end
            end
        end
    end

    // Per-cycle compare against the model, plus a record of every observed tx_done pulse.
    int  done_cnt   = 0;
    int  done_cyc   = 0;
    int  done_tick  = 0;
    bit  done_ready = 1'b0;

    initial begin
        forever begin
            @(negedge Clk);
            if (tx_done === 1'b1) begin
                done_cnt++;
                done_cyc   = cyc;
                done_tick  = tick_cnt;
                done_ready = bus.tx_ready;
            end
            if (Rst_n) begin
                check("cyc_tx",    tx,           m_active ? m_bits[elapsed / OS] : 1'b1);
                check("cyc_ready", bus.tx_ready, !m_active);
                check("cyc_busy",  busy,         m_active);
                check("cyc_done",  tx_done,      exp_done);
            end
        end
    end

    int tick_period = 1;
    int tick_phase  = 0;

    initial begin
        tick = 1'b0;
        forever begin
            @(negedge Clk);
            tick_phase++;
            tick = (tick_phase % tick_period == 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_acc(input int target, input string name);
        int n = 0;
        while (acc_cnt < target && n < 3000) begin
            @(negedge Clk);
            n++;
        end
        check(name, acc_cnt >= target, 1);
    endtask

    // Leaves the caller at the first negedge after the accept edge (zero ticks into the start bit).
    task automatic send_start(input logic [7:0] d, input logic [3:0] n, input logic s2);
        int base = acc_cnt;
        bus.tx_data  = d;
        bus.nbits    = n;
        bus.stop2    = s2;
        bus.tx_valid = 1'b1;
        wait_acc(base + 1, "accept");
        bus.tx_valid = 1'b0;
        bus.tx_data  = ~d;
        bus.nbits    = n ^ 4'hF;
        bus.stop2    = ~s2;
    endtask

    task automatic wait_done(input string name);
        int base = done_cnt;
        int n = 0;
        while (done_cnt == base && n < 4000) begin
            @(negedge Clk);
            n++;
        end
        check(name, done_cnt - base, 1);
    endtask

    logic [7:0] a5_bits;
    int a1, a2, a3, dbase;

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        bus.nbits    = 4'd8;
        bus.stop2    = 1'b0;
`ifdef UART_TX_PARITY_EN
        bus.parity_en  = 1'b0;
        bus.parity_odd = 1'b0;
`endif

        // Reset values, then a long idle with a tick on every cycle.
        #2 Rst_n = 1'b0;
        #1;
        check("rst_tx",    tx,           1);
        check("rst_ready", bus.tx_ready, 1);
        check("rst_busy",  busy,         0);
        check("rst_done",  tx_done,      0);
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (100) @(negedge Clk);
        check("idle_done_count", done_cnt, 0);
        check("idle_tx",         tx,       1);

        // 0xA5, 8 data bits, one stop: sample mid-bit of every bit period.
        a5_bits = 8'hA5;
        send_start(8'hA5, 4'd8, 1'b0);
        repeat (8) @(negedge Clk);
        check("a5_start", tx, 0);
        for (int b = 0; b < 8; b++) begin
            repeat (16) @(negedge Clk);
            check("a5_data", tx, a5_bits[b]);
        end
        repeat (16) @(negedge Clk);
        check("a5_stop", tx, 1);
        wait_done("a5_done");
        check("a5_latency",        done_cyc - acc_cyc, 160);
        check("a5_ready_with_done", done_ready,        1);

        // Five bits, two stops, tick every 4th cycle: 8 bit periods = 128 ticks.
        tick_period = 4;
        repeat (2) @(negedge Clk);
        send_start(8'h1F, 4'd5, 1'b1);
        wait_done("n5_done");
        check("n5_ticks", done_tick - acc_tick, 128);
        send_start(8'hE0, 4'd5, 1'b1);
        wait_done("n5_zero_done");
        check("n5_zero_ticks", done_tick - acc_tick, 128);

        // nbits clamping: 2 -> 5 and 15 -> 8.
        tick_period = 1;
        repeat (2) @(negedge Clk);
        send_start(8'hE5, 4'd2, 1'b0);
        wait_done("clamp_lo_done");
        check("clamp_lo_latency", done_cyc - acc_cyc, 112);
        send_start(8'h96, 4'd15, 1'b0);
        wait_done("clamp_hi_done");
        check("clamp_hi_latency", done_cyc - acc_cyc, 160);

        // tx_valid held across three frames with payload changes mid-frame.
        repeat (3) @(negedge Clk);
        dbase = done_cnt;
        bus.tx_data  = 8'h00;
        bus.nbits    = 4'd8;
        bus.stop2    = 1'b0;
        bus.tx_valid = 1'b1;
        wait_acc(acc_cnt + 1, "b2b_acc1");
        a1 = acc_cyc;
        repeat (20) @(negedge Clk);
        bus.tx_data = 8'hFF;
        wait_acc(acc_cnt + 1, "b2b_acc2");
        a2 = acc_cyc;
        repeat (20) @(negedge Clk);
        bus.tx_data = 8'h55;
        wait_acc(acc_cnt + 1, "b2b_acc3");
        a3 = acc_cyc;
        bus.tx_valid = 1'b0;
        repeat (20) @(negedge Clk);
        bus.tx_data = 8'hAA;
        for (int n = 0; n < 400 && done_cnt < dbase + 3; n++)
            @(negedge Clk);
        check("b2b_gap12",      a2 - a1,          161);
        check("b2b_gap23",      a3 - a2,          161);
        check("b2b_done_count", done_cnt - dbase, 3);

        // Reset during data bit 3 of 0xC3 (that bit is 0, so the forced idle level is visible).
        repeat (3) @(negedge Clk);
        send_start(8'hC3, 4'd8, 1'b0);
        repeat (70) @(negedge Clk);
        check("c3_bit3", tx, 0);
        dbase = done_cnt;
        #3 Rst_n = 1'b0;
        #1;
        check("c3_rst_tx",    tx,           1);
        check("c3_rst_busy",  busy,         0);
        check("c3_rst_ready", bus.tx_ready, 1);
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (5) @(negedge Clk);
        check("c3_no_done", done_cnt - dbase, 0);
        send_start(8'h3C, 4'd8, 1'b0);
        wait_done("post_rst_done");
        check("post_rst_latency", done_cyc - acc_cyc, 160);

`ifdef UART_TX_PARITY_EN
        // 0x07 has three ones: even parity bit 1, odd parity bit 0; 11 bit periods.
        repeat (2) @(negedge Clk);
        bus.parity_en  = 1'b1;
        bus.parity_odd = 1'b0;
        send_start(8'h07, 4'd8, 1'b0);
        bus.parity_en  = 1'b0;
        bus.parity_odd = 1'b1;
        repeat (152) @(negedge Clk);
        check("par_even_bit", tx, 1);
        wait_done("par_even_done");
        check("par_even_latency", done_cyc - acc_cyc, 176);

        bus.parity_en  = 1'b1;
        bus.parity_odd = 1'b1;
        send_start(8'h07, 4'd8, 1'b0);
        bus.parity_en  = 1'b0;
        bus.parity_odd = 1'b0;
        repeat (152) @(negedge Clk);
        check("par_odd_bit", tx, 0);
        wait_done("par_odd_done");
        check("par_odd_latency", done_cyc - acc_cyc, 176);
`endif

        repeat (5) @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
